// File: rtl/xrog_treaty_scheduler.sv
// xrog_treaty_scheduler
//   Round-robin front end for the XROG treaty manager. Picks one pending
//   requester at a time, forwards its treaty type and signatories to the
//   manager, captures the returned duration and parks it in a free slot of
//   the active-treaty table. Live slots count down on day ticks. A slot that
//   reaches zero is released and flagged in a sticky expired mask.
//
// Parameters
//   N_REQ   number of requesters (2..8)
//   N_SLOT  number of active-treaty slots (power of 2, 2..16)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/type/sig  per-requester request level and payload
//   req_grant           one-hot, single-cycle grant (combinational in IDLE)
//   tm_*                request interface to the treaty manager
//   tm_treaty_duration  manager result, valid the cycle after tm_treaty_request
//   day_tick            one treaty day elapsed
//   slot_busy/owner     table occupancy and owning requester (3 bits per slot)
//   expired_mask        sticky expiry flags; expire_clr is write-1-to-clear
//   sched_busy          a transaction is in flight
module xrog_treaty_scheduler #(
  parameter int N_REQ  = 4,
  parameter int N_SLOT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [8*N_REQ-1:0]    req_type,
  input  logic [32*N_REQ-1:0]   req_sig_a,
  input  logic [32*N_REQ-1:0]   req_sig_b,
  output logic [N_REQ-1:0]      req_grant,
  output logic [7:0]            tm_treaty_type,
  output logic [31:0]           tm_signatory_a,
  output logic [31:0]           tm_signatory_b,
  output logic                  tm_treaty_request,
  input  logic [31:0]           tm_treaty_duration,
  input  logic                  day_tick,
  output logic [N_SLOT-1:0]     slot_busy,
  output logic [N_SLOT*3-1:0]   slot_owner,
  output logic [N_SLOT-1:0]     expired_mask,
  input  logic [N_SLOT-1:0]     expire_clr,
  output logic                  sched_busy
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int SLOT_W = $clog2(N_SLOT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_STORE   = 2'd3;

  logic [1:0]        state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  win_q;
  logic [31:0]       dur_q;

  logic [PTR_W-1:0]  winner;
  logic              win_found;
  logic [PTR_W:0]    cand_sum;
  logic [PTR_W-1:0]  cand;
  logic [SLOT_W-1:0] free_idx;
  logic              free_found;
  logic              grant_go;
  logic              store_en;

  logic [31:0]       remaining [N_SLOT];
  logic [2:0]        owner     [N_SLOT];

  // Round-robin search: walk from rr_ptr upward, wrapping at N_REQ.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand_sum >= (PTR_W+1)'(N_REQ))
        cand_sum = cand_sum - (PTR_W+1)'(N_REQ);
      cand = cand_sum[PTR_W-1:0];
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
  end

  // Lowest-index free slot, from registered occupancy only: a slot freed by
  // expiry on this edge becomes visible one cycle later.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int unsigned s = 0; s < N_SLOT; s++) begin
      if (!free_found && !slot_busy[s]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(s);
      end
    end
  end

  assign grant_go = rst_n && (state == S_IDLE) && win_found && free_found;
  assign store_en = (state == S_STORE);

  always_comb begin
    req_grant = '0;
    if (grant_go)
      req_grant = N_REQ'(1) << winner;
  end

  assign tm_treaty_request = (state == S_ISSUE);
  assign sched_busy        = (state != S_IDLE);

  // Transaction sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      win_q          <= '0;
      dur_q          <= '0;
      tm_treaty_type <= '0;
      tm_signatory_a <= '0;
      tm_signatory_b <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_go) begin
            tm_treaty_type <= req_type[8*winner +: 8];
            tm_signatory_a <= req_sig_a[32*winner +: 32];
            tm_signatory_b <= req_sig_b[32*winner +: 32];
            win_q          <= winner;
            rr_ptr         <= (winner == PTR_W'(N_REQ-1)) ? '0 : winner + 1'b1;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE:   state <= S_CAPTURE;
        S_CAPTURE: begin
          dur_q <= tm_treaty_duration;
          state <= S_STORE;
        end
        S_STORE:   state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Active-treaty table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_busy    <= '0;
      expired_mask <= '0;
      for (int unsigned s = 0; s < N_SLOT; s++) begin
        remaining[s] <= '0;
        owner[s]     <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < N_SLOT; s++) begin
        if (store_en && (free_idx == SLOT_W'(s))) begin
          // The slot being filled skips any coincident tick.
          slot_busy[s]    <= 1'b1;
          remaining[s]    <= (dur_q == '0) ? 32'd1 : dur_q;
          owner[s]        <= 3'(win_q);
          expired_mask[s] <= 1'b0;
        end else begin
          // Expiry set dominates a simultaneous clear.
          expired_mask[s] <= (expired_mask[s] & ~expire_clr[s]) |
                             (day_tick & slot_busy[s] & (remaining[s] <= 32'd1));
          if (day_tick && slot_busy[s]) begin
            if (remaining[s] > 32'd1) begin
              remaining[s] <= remaining[s] - 32'd1;
            end else begin
              remaining[s] <= '0;
              slot_busy[s] <= 1'b0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    slot_owner = '0;
    for (int unsigned s = 0; s < N_SLOT; s++)
      slot_owner[3*s +: 3] = owner[s];
  end

endmodule

// File: tb/tb_xrog_treaty_scheduler.sv
// tb_xrog_treaty_scheduler
//   Self-checking bench: table of directed requests, hand-written sequences
//   for fairness / full table / expiry / tick collision / mid-transaction
//   reset, then randomized traffic against a transaction-level model.
module tb_xrog_treaty_scheduler;

  localparam int N_REQ  = 4;
  localparam int N_SLOT = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_REQ-1:0]     req_valid;
  logic [8*N_REQ-1:0]   req_type;
  logic [32*N_REQ-1:0]  req_sig_a;
  logic [32*N_REQ-1:0]  req_sig_b;
  logic [N_REQ-1:0]     req_grant;
  logic [7:0]           tm_treaty_type;
  logic [31:0]          tm_signatory_a;
  logic [31:0]          tm_signatory_b;
  logic                 tm_treaty_request;
  logic [31:0]          tm_treaty_duration = '0;
  logic                 day_tick;
  logic [N_SLOT-1:0]    slot_busy;
  logic [N_SLOT*3-1:0]  slot_owner;
  logic [N_SLOT-1:0]    expired_mask;
  logic [N_SLOT-1:0]    expire_clr;
  logic                 sched_busy;

  always #5 clk = ~clk;

  xrog_treaty_scheduler #(.N_REQ(N_REQ), .N_SLOT(N_SLOT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_type(req_type),
    .req_sig_a(req_sig_a), .req_sig_b(req_sig_b),
    .req_grant(req_grant),
    .tm_treaty_type(tm_treaty_type), .tm_signatory_a(tm_signatory_a),
    .tm_signatory_b(tm_signatory_b), .tm_treaty_request(tm_treaty_request),
    .tm_treaty_duration(tm_treaty_duration),
    .day_tick(day_tick),
    .slot_busy(slot_busy), .slot_owner(slot_owner),
    .expired_mask(expired_mask), .expire_clr(expire_clr),
    .sched_busy(sched_busy)
  );

  // Stub manager: type 1 lasts a year, any other type lasts 'type' days.
  function automatic logic [31:0] dur_of(input logic [7:0] t);
    return (t == 8'd1) ? 32'd365 : {24'd0, t};
  endfunction

  always @(posedge clk)
    if (tm_treaty_request) tm_treaty_duration <= dur_of(tm_treaty_type);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          m_phase;          // cycles since the grant, 0 = waiting
  int          m_ptr, m_win;
  logic [7:0]  m_type;
  logic [31:0] m_sa, m_sb, m_dur;
  logic [31:0] m_rem [N_SLOT];   // 0 means the slot is free
  logic [2:0]  m_own [N_SLOT];
  bit          m_exp [N_SLOT];
  int          last_w;

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_win = 0;
    m_type = '0; m_sa = '0; m_sb = '0; m_dur = '0;
    for (int s = 0; s < N_SLOT; s++) begin
      m_rem[s] = '0; m_own[s] = '0; m_exp[s] = 0;
    end
  endtask

  task automatic model_eval(output int w);
    bit free = 0;
    w = -1;
    for (int s = 0; s < N_SLOT; s++) if (m_rem[s] == 0) free = 1;
    if (m_phase == 0 && free)
      for (int k = 0; k < N_REQ; k++) begin
        int idx = (m_ptr + k) % N_REQ;
        if (w < 0 && req_valid[idx]) w = idx;
      end
  endtask

  task automatic model_update(input int w);
    int ss = -1;
    bit ex;
    if (m_phase == 3)
      for (int s = 0; s < N_SLOT; s++) if (ss < 0 && m_rem[s] == 0) ss = s;
    for (int s = 0; s < N_SLOT; s++) begin
      if (s == ss) begin
        m_rem[s] = (m_dur == 0) ? 32'd1 : m_dur;
        m_own[s] = 3'(m_win);
        m_exp[s] = 0;
      end else begin
        ex = 0;
        if (day_tick && m_rem[s] != 0) begin
          if (m_rem[s] > 1) m_rem[s] = m_rem[s] - 1;
          else begin m_rem[s] = 0; ex = 1; end
        end
        m_exp[s] = (m_exp[s] && !expire_clr[s]) || ex;
      end
    end
    case (m_phase)
      0: if (w >= 0) begin
           m_win = w;
           m_type = req_type[8*w +: 8];
           m_sa = req_sig_a[32*w +: 32];
           m_sb = req_sig_b[32*w +: 32];
           m_ptr = (w + 1) % N_REQ;
           m_phase = 1;
         end
      1: m_phase = 2;
      2: begin m_dur = dur_of(m_type); m_phase = 3; end
      default: m_phase = 0;
    endcase
  endtask

  task automatic compare_all(input int w);
    logic [N_REQ-1:0]    eg;
    logic [N_SLOT-1:0]   eb, ee;
    logic [3*N_SLOT-1:0] mown, eown;
    eg = (w >= 0) ? (N_REQ'(1) << w) : '0;
    eb = '0; ee = '0; mown = '0; eown = '0;
    for (int s = 0; s < N_SLOT; s++) begin
      eb[s] = (m_rem[s] != 0);
      ee[s] = m_exp[s];
      if (m_rem[s] != 0) begin
        mown[3*s +: 3] = 3'b111;
        eown[3*s +: 3] = m_own[s];
      end
    end
    chk("grant", req_grant, eg);
    chk("tm_request", tm_treaty_request, m_phase == 1);
    chk("sched_busy", sched_busy, m_phase != 0);
    chk("slot_busy", slot_busy, eb);
    chk("expired_mask", expired_mask, ee);
    chk("slot_owner", slot_owner & mown, eown);
    chk("tm_type", tm_treaty_type, m_type);
    chk("tm_sig_a", tm_signatory_a, m_sa);
    chk("tm_sig_b", tm_signatory_b, m_sb);
  endtask

  // One clock: check at offset, advance the model on the edge, end at negedge.
  task automatic step();
    int w;
    #1;
    model_eval(w);
    compare_all(w);
    last_w = w;
    @(posedge clk);
    model_update(w);
    @(negedge clk);
  endtask

  task automatic set_all_data(input logic [7:0] t);
    for (int i = 0; i < N_REQ; i++) begin
      req_type[8*i +: 8]   = t;
      req_sig_a[32*i +: 32] = 32'hA000_0000 | i;
      req_sig_b[32*i +: 32] = 32'hB000_0000 | i;
    end
  endtask

  task automatic do_reset();
    int w;
    rst_n = 1'b0;
    req_valid = '0; day_tick = 1'b0; expire_clr = '0;
    set_all_data(8'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    model_eval(w);
    compare_all(w);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [7:0] typ;
    logic [3:0] grant;
    int         win;
    int         slot;
  } vec_t;

  vec_t tbl [9];
  int   gidx [$];
  int   gcyc [$];
  bit         pend   [N_REQ];
  logic [7:0]  p_type [N_REQ];
  logic [31:0] p_sa   [N_REQ];
  logic [31:0] p_sb   [N_REQ];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Pointer starts at 0 and advances past each winner.
    tbl[0] = '{4'b0001, 8'd1,   4'b0001, 0, 0};
    tbl[1] = '{4'b0001, 8'h11,  4'b0001, 0, 1};
    tbl[2] = '{4'b1010, 8'h12,  4'b0010, 1, 2};
    tbl[3] = '{4'b1010, 8'h13,  4'b1000, 3, 3};
    tbl[4] = '{4'b0110, 8'h14,  4'b0010, 1, 4};
    tbl[5] = '{4'b0100, 8'h15,  4'b0100, 2, 5};
    tbl[6] = '{4'b0011, 8'h16,  4'b0001, 0, 6};
    tbl[7] = '{4'b1111, 8'h17,  4'b0010, 1, 7};
    tbl[8] = '{4'b1111, 8'h20,  4'b0000, 0, 0};   // table full: no grant

    // ---- table-driven directed requests ----
    do_reset();
    for (int i = 0; i < 9; i++) begin
      req_valid = tbl[i].valid;
      set_all_data(tbl[i].typ);
      #1 chk("tbl_grant", req_grant, tbl[i].grant);
      step();
      if (tbl[i].grant != '0) begin
        req_valid = '0;
        #1;
        chk("tbl_request", tm_treaty_request, 1'b1);
        chk("tbl_type", tm_treaty_type, tbl[i].typ);
        chk("tbl_sig_a", tm_signatory_a, 32'hA000_0000 | tbl[i].win);
        step(); step(); step();
        #1;
        chk("tbl_slot_busy", slot_busy[tbl[i].slot], 1'b1);
        chk("tbl_owner", slot_owner[3*tbl[i].slot +: 3], 3'(tbl[i].win));
      end else begin
        repeat (4) begin
          #1 chk("tbl_full_grant", req_grant, '0);
          step();
        end
        req_valid = '0;
      end
    end

    // ---- fairness and full table: all requesters held high ----
    do_reset();
    req_valid = '1;
    set_all_data(8'd3);
    for (int c = 0; c < 80; c++) begin
      #1;
      for (int i = 0; i < N_REQ; i++)
        if (req_grant[i]) begin gidx.push_back(i); gcyc.push_back(c); end
      step();
    end
    chk("rr_count", gidx.size(), 8);
    for (int i = 0; i < gidx.size(); i++) begin
      chk("rr_order", gidx[i], i % N_REQ);
      if (i > 0) chk("rr_spacing_ge4", (gcyc[i] - gcyc[i-1]) >= 4, 1'b1);
    end
    req_valid = '0;
    day_tick = 1'b1; step(); day_tick = 1'b0; step();
    day_tick = 1'b1; step(); day_tick = 1'b0; step();
    day_tick = 1'b1; req_valid = 4'b0001;
    #1 chk("full_no_grant_expiry_cycle", req_grant, '0);
    step();
    day_tick = 1'b0;
    #1;
    chk("full_all_free", slot_busy, '0);
    chk("full_all_expired", expired_mask, 8'hFF);
    chk("full_grant_after_expiry", req_grant, 4'b0001);
    step();
    req_valid = '0;
    step(); step(); step();
    #1;
    chk("refill_busy", slot_busy, 8'h01);
    chk("refill_expired", expired_mask, 8'hFE);
    expire_clr = 8'h0F; step(); expire_clr = '0;
    #1 chk("expire_clr", expired_mask, 8'hF0);

    // ---- expiry with duration 2, clear colliding with set ----
    do_reset();
    req_valid = 4'b0001; set_all_data(8'd2);
    #1 chk("exp_grant", req_grant, 4'b0001);
    step(); req_valid = '0;
    step(); step(); step();
    #1 chk("exp_stored", slot_busy, 8'h01);
    day_tick = 1'b1; step(); day_tick = 1'b0;
    #1 chk("exp_after1_busy", slot_busy, 8'h01);
    chk("exp_after1_mask", expired_mask, 8'h00);
    day_tick = 1'b1; expire_clr = 8'h01; step(); day_tick = 1'b0; expire_clr = '0;
    #1 chk("exp_after2_busy", slot_busy, 8'h00);
    chk("exp_set_wins", expired_mask, 8'h01);
    expire_clr = 8'h01; step(); expire_clr = '0;
    #1 chk("exp_cleared", expired_mask, 8'h00);

    // ---- day tick during STORE ----
    do_reset();
    req_valid = 4'b0001; set_all_data(8'd3);
    step(); req_valid = '0;
    step(); step();
    day_tick = 1'b1; step(); day_tick = 1'b0;
    #1 chk("coll_stored", slot_busy, 8'h01);
    for (int t = 0; t < 2; t++) begin
      day_tick = 1'b1; step(); day_tick = 1'b0;
      #1 chk("coll_still_busy", slot_busy, 8'h01);
    end
    day_tick = 1'b1; step(); day_tick = 1'b0;
    #1 chk("coll_expired_busy", slot_busy, 8'h00);
    chk("coll_expired_mask", expired_mask, 8'h01);

    // ---- reset while ISSUE ----
    do_reset();
    req_valid = 4'b0100; set_all_data(8'd5);
    #1 chk("rst_pre_grant", req_grant, 4'b0100);
    step(); req_valid = '0;
    #1 chk("rst_in_issue", tm_treaty_request, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_request", tm_treaty_request, 1'b0);
    chk("rst_sched_busy", sched_busy, 1'b0);
    chk("rst_slot_busy", slot_busy, '0);
    chk("rst_tm_type", tm_treaty_type, 8'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    #1 chk("rst_no_store", slot_busy, '0);
    req_valid = 4'b1001;
    #1 chk("rst_ptr_zero", req_grant, 4'b0001);
    step(); req_valid = '0;
    repeat (3) step();

    // ---- randomized traffic against the model ----
    do_reset();
    for (int i = 0; i < N_REQ; i++) pend[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      day_tick   = ($urandom_range(0, 3) == 0);
      expire_clr = ($urandom_range(0, 7) == 0) ? N_SLOT'($urandom) : '0;
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          int t = $urandom_range(0, 5);
          pend[i]   = 1;
          p_type[i] = (t == 0) ? 8'd0 : 8'(t + 1);
          p_sa[i]   = $urandom;
          p_sb[i]   = $urandom;
        end
        req_valid[i]          = pend[i];
        req_type[8*i +: 8]    = p_type[i];
        req_sig_a[32*i +: 32] = p_sa[i];
        req_sig_b[32*i +: 32] = p_sb[i];
      end
      step();
      if (last_w >= 0) pend[last_w] = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
